// File: rtl/serial_comp_16_if.sv
// Handshake bundle for the bit-serial complement unit: operand channel (in_*, a, neg)
// and result channel (out_*, s, ovf), each with its own valid/ready pair.
// Ports: master = operand producer / result consumer, slave = the complement unit.
interface serial_comp_16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             neg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             ovf;

  modport master (
    output in_valid, a, neg, out_ready,
    input  in_ready, out_valid, s, ovf
  );

  modport slave (
    input  in_valid, a, neg, out_ready,
    output in_ready, out_valid, s, ovf
  );
endinterface

// File: rtl/serial_comp_16.sv
// Purpose: bit-serial ones'/two's complement of a WIDTH-bit word, LSB first.
// Latency: out_valid rises WIDTH cycles after operand acceptance; initiation interval WIDTH+2.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE, nothing queued.
// Ports: clk, rst (async, active-high); bus (slave): in_valid/in_ready/a/neg in,
//        out_valid/out_ready/s/ovf out (all outputs registered).
module serial_comp_16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  serial_comp_16_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic               ovf_nxt_q, ovf_nxt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               ovf_q, ovf_d;
  logic               bit_r;

  // Only the most negative value overflows under negation.
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    mode_d    = mode_q;
    ovf_nxt_d = ovf_nxt_q;
    s_d       = s_q;
    ovf_d     = ovf_q;
    bit_r     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d      = bus.a;
          carry_d   = bus.neg;
          mode_d    = bus.neg;
          ovf_nxt_d = bus.neg & (bus.a == MOST_NEG);
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // Negation as ~a + 1: the +1 ripples through while inverted bits are 1.
        // Gating with the mode keeps the carry dead in ones' mode.
        bit_r   = ~sr_q[0] ^ carry_q;
        carry_d = mode_q & ~sr_q[0] & carry_q;
        sr_d    = {1'b0, sr_q[WIDTH-1:1]};
        res_d   = {bit_r, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = res_d;
          ovf_d   = ovf_nxt_q;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      mode_q    <= 1'b0;
      ovf_nxt_q <= 1'b0;
      s_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      mode_q    <= mode_d;
      ovf_nxt_q <= ovf_nxt_d;
      s_q       <= s_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.ovf       = ovf_q;

endmodule
